// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with a registered (Moore) match output.
// Pattern length 1..MAX_LEN, overlap / non-overlap mode, sticky config error flag and a
// saturating match counter. Define SEQDET_MASK_EN to add a per-bit don't-care mask input.
module seq_detector_param #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
`ifdef SEQDET_MASK_EN
    input  logic [MAX_LEN-1:0] pat_mask,
`endif
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err,
    output logic               configured
);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        HUNT  = 2'd1,
        MATCH = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t               state, state_n;
    logic [MAX_LEN-1:0]   hist, hist_n;
    logic [LEN_W-1:0]     fill, fill_n;
    logic [MAX_LEN-1:0]   pat_r, pat_r_n;
    logic [LEN_W-1:0]     len_r, len_r_n;
    logic                 mode_r, mode_r_n;
    logic [CNT_W-1:0]     cnt_n;
    logic                 z_n, cfg_err_n, configured_n;
`ifdef SEQDET_MASK_EN
    logic [MAX_LEN-1:0]   mask_r, mask_r_n;
`endif

    logic [MAX_LEN-1:0]   hist_sh;
    logic [LEN_W-1:0]     fill_inc;
    logic [MAX_LEN-1:0]   cmp_mask;
    logic                 hit;
    logic                 len_legal;

    // Candidate history/fill for an accepted bit and the resulting hit decision
    always_comb begin
        hist_sh   = {hist[MAX_LEN-2:0], x};
        fill_inc  = (fill >= MAX_L) ? MAX_L : fill + LEN_W'(1);
        cmp_mask  = ~({MAX_LEN{1'b1}} << len_r);
`ifdef SEQDET_MASK_EN
        cmp_mask  = cmp_mask & mask_r;
`endif
        hit       = (fill_inc >= len_r) && (((hist_sh ^ pat_r) & cmp_mask) == '0);
        len_legal = (pat_len != '0) && (pat_len <= MAX_L);
    end

    // Next-state and output logic; load has priority over an accepted bit
    always_comb begin
        state_n      = state;
        hist_n       = hist;
        fill_n       = fill;
        pat_r_n      = pat_r;
        len_r_n      = len_r;
        mode_r_n     = mode_r;
        cnt_n        = match_cnt;
        cfg_err_n    = cfg_err;
        configured_n = configured;
`ifdef SEQDET_MASK_EN
        mask_r_n     = mask_r;
`endif
        if (load) begin
            cnt_n = '0;
            if (len_legal) begin
                pat_r_n      = pattern;
                len_r_n      = pat_len;
                mode_r_n     = overlap;
`ifdef SEQDET_MASK_EN
                mask_r_n     = pat_mask;
`endif
                hist_n       = '0;
                fill_n       = '0;
                cfg_err_n    = 1'b0;
                configured_n = 1'b1;
                state_n      = HUNT;
            end else begin
                cfg_err_n    = 1'b1;
                configured_n = 1'b0;
                state_n      = UNCFG;
            end
        end else if (x_valid && (state != UNCFG)) begin
            hist_n = hist_sh;
            if (hit) begin
                state_n = MATCH;
                fill_n  = mode_r ? fill_inc : '0;
                cnt_n   = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
            end else begin
                state_n = HUNT;
                fill_n  = fill_inc;
            end
        end
        z_n = (state_n == MATCH);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UNCFG;
            hist       <= '0;
            fill       <= '0;
            pat_r      <= '0;
            len_r      <= '0;
            mode_r     <= 1'b0;
            match_cnt  <= '0;
            z          <= 1'b0;
            cfg_err    <= 1'b0;
            configured <= 1'b0;
`ifdef SEQDET_MASK_EN
            mask_r     <= '0;
`endif
        end else begin
            state      <= state_n;
            hist       <= hist_n;
            fill       <= fill_n;
            pat_r      <= pat_r_n;
            len_r      <= len_r_n;
            mode_r     <= mode_r_n;
            match_cnt  <= cnt_n;
            z          <= z_n;
            cfg_err    <= cfg_err_n;
            configured <= configured_n;
`ifdef SEQDET_MASK_EN
            mask_r     <= mask_r_n;
`endif
        end
    end

endmodule
